// File: rtl/airlock_pkg.sv
// rtl/airlock_pkg.sv - shared state encoding and 7-segment constants for the airlock timer
package airlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SAT  = 2'b10
    } timer_state_t;

    // Active-low segments, bit order g..a
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_P     = 7'b0001100;

endpackage

// File: rtl/seg7_digit.sv
// rtl/seg7_digit.sv - combinational active-low 7-segment decoder with blanking
module seg7_digit
    import airlock_pkg::*;
#(
    parameter int COUNT_WIDTH = 3
) (
    input  logic [COUNT_WIDTH-1:0] i_value,
    input  logic                   i_blank,
    output logic [6:0]             o_seg
);

    logic [31:0] w_value;
    assign w_value = 32'(i_value);

    // Values beyond a single octal digit show blank rather than garbage
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (w_value)
                32'd0:   o_seg = SEG_0;
                32'd1:   o_seg = SEG_1;
                32'd2:   o_seg = SEG_2;
                32'd3:   o_seg = SEG_3;
                32'd4:   o_seg = SEG_4;
                32'd5:   o_seg = SEG_5;
                32'd6:   o_seg = SEG_6;
                32'd7:   o_seg = SEG_7;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/airlock_timer.sv
// rtl/airlock_timer.sv - elapsed-unit counter feeding the airlock interlock FSMs
module airlock_timer
    import airlock_pkg::*;
#(
    parameter int TICK_CYCLES = 250000000,
    parameter int PS_WIDTH    = 28,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   rstCounterA,
    input  logic                   rstCounterB,
    input  logic                   hold,
    output logic [COUNT_WIDTH-1:0] counterVal,
    output logic                   tick,
    output logic                   saturated,
    output logic                   running,
    output logic [6:0]             display
);

    localparam logic [PS_WIDTH-1:0]    PS_LAST   = PS_WIDTH'(TICK_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

    timer_state_t            r_state,     w_state_next;
    logic [PS_WIDTH-1:0]     r_prescaler, w_prescaler_next;
    logic [COUNT_WIDTH-1:0]  r_count,     w_count_next;
    logic                    r_tick,      w_tick_next;
    logic                    r_saturated;
    logic                    r_running;
    logic                    w_restart;
    logic [COUNT_WIDTH-1:0]  w_count_inc;

    assign w_restart   = rstCounterA | rstCounterB;
    assign w_count_inc = r_count + COUNT_WIDTH'(1);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_prescaler <= '0;
            r_count     <= '0;
            r_tick      <= 1'b0;
            r_saturated <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_prescaler <= w_prescaler_next;
            r_count     <= w_count_next;
            r_tick      <= w_tick_next;
            r_saturated <= (w_state_next == ST_SAT);
            r_running   <= (w_state_next == ST_RUN);
        end
    end

    // Restart outranks hold, which outranks prescaler advance
    always_comb begin
        w_state_next     = r_state;
        w_prescaler_next = r_prescaler;
        w_count_next     = r_count;
        w_tick_next      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_restart) begin
                    w_state_next     = ST_RUN;
                    w_prescaler_next = '0;
                    w_count_next     = '0;
                end
            end
            ST_RUN: begin
                if (w_restart) begin
                    w_prescaler_next = '0;
                    w_count_next     = '0;
                end else if (!hold) begin
                    if (r_prescaler == PS_LAST) begin
                        w_prescaler_next = '0;
                        w_count_next     = w_count_inc;
                        w_tick_next      = 1'b1;
                        if (w_count_inc == COUNT_MAX) begin
                            w_state_next = ST_SAT;
                        end
                    end else begin
                        w_prescaler_next = r_prescaler + PS_WIDTH'(1);
                    end
                end
            end
            ST_SAT: begin
                w_prescaler_next = '0;
                w_count_next     = COUNT_MAX;
                if (w_restart) begin
                    w_state_next = ST_RUN;
                    w_count_next = '0;
                end
            end
            default: begin
                w_state_next     = ST_IDLE;
                w_prescaler_next = '0;
                w_count_next     = '0;
            end
        endcase
    end

    seg7_digit #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_seg7_digit (
        .i_value (r_count),
        .i_blank ((r_state != ST_RUN) && (r_state != ST_SAT)),
        .o_seg   (display)
    );

    assign counterVal = r_count;
    assign tick       = r_tick;
    assign saturated  = r_saturated;
    assign running    = r_running;

endmodule

// File: tb/tb_airlock_timer.sv
// tb/tb_airlock_timer.sv - scoreboard bench for airlock_timer against an elapsed-edge model
module tb_airlock_timer;

    localparam int T    = 4;
    localparam int NMAX = 7;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       rstCounterA = 1'b0;
    logic       rstCounterB = 1'b0;
    logic       hold        = 1'b0;
    logic [2:0] counterVal;
    logic       tick;
    logic       saturated;
    logic       running;
    logic [6:0] display;

    airlock_timer #(
        .TICK_CYCLES (T),
        .PS_WIDTH    (28),
        .COUNT_WIDTH (3)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .rstCounterA (rstCounterA),
        .rstCounterB (rstCounterB),
        .hold        (hold),
        .counterVal  (counterVal),
        .tick        (tick),
        .saturated   (saturated),
        .running     (running),
        .display     (display)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Expected snapshot: {count[3], tick, saturated, running, display[7]}
    logic [12:0] exp_q[$];

    logic [6:0] digits [8];
    initial begin
        digits[0] = 7'b1000000; digits[1] = 7'b1111001;
        digits[2] = 7'b0100100; digits[3] = 7'b0110000;
        digits[4] = 7'b0011001; digits[5] = 7'b0010010;
        digits[6] = 7'b0000010; digits[7] = 7'b1111000;
    end

    // Model: elapsed unheld edges since the last restart, capped at NMAX units
    bit m_active = 0;
    int m_elapsed = 0;

    function automatic logic [12:0] model_edge(bit a, bit b, bit h);
        bit   t = 0;
        int   units;
        logic [6:0] seg;
        if (a || b) begin
            m_active  = 1;
            m_elapsed = 0;
        end else if (m_active && m_elapsed < NMAX * T && !h) begin
            m_elapsed++;
            t = (m_elapsed % T) == 0;
        end
        units = m_active ? m_elapsed / T : 0;
        seg   = m_active ? digits[units] : 7'b1111111;
        return {3'(units), t, m_active && units == NMAX, m_active && units < NMAX, seg};
    endfunction

    task automatic step(input bit a, input bit b, input bit h);
        rstCounterA = a;
        rstCounterB = b;
        hold        = h;
        @(posedge clock);
        exp_q.push_back(model_edge(a, b, h));
        #1;
    endtask

    task automatic idle(input int n, input bit h);
        for (int i = 0; i < n; i++) step(0, 0, h);
    endtask

    always @(negedge clock) begin
        logic [12:0] e;
        logic [12:0] g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {counterVal, tick, saturated, running, display};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL cycle_outputs t=%0t got cnt=%0d tick=%b sat=%b run=%b disp=%b exp cnt=%0d tick=%b sat=%b run=%b disp=%b",
                         $time, g[12:10], g[9], g[8], g[7], g[6:0], e[12:10], e[9], e[8], e[7], e[6:0]);
            end
        end
    end

    task automatic check_async_reset();
        @(negedge clock);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({counterVal, tick, saturated, running, display} !== {3'd0, 1'b0, 1'b0, 1'b0, 7'b1111111}) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d tick=%b sat=%b run=%b disp=%b exp cnt=0 tick=0 sat=0 run=0 disp=1111111",
                     counterVal, tick, saturated, running, display);
        end
        m_active  = 0;
        m_elapsed = 0;
        repeat (3) @(posedge clock);
        #1 rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;

        idle(20, 0);

        // basic count up to saturation, then restart from A
        step(0, 1, 0);
        idle(16, 0);
        idle(12, 0);
        idle(10, 0);
        step(1, 0, 0);
        idle(3, 0);

        // hold mid-interval
        step(0, 1, 0);
        idle(2, 0);
        idle(10, 1);
        idle(4, 0);

        // simultaneous restart at count 3, prescaler 2
        step(1, 0, 0);
        idle(14, 0);
        step(1, 1, 0);
        idle(6, 0);

        // restart while held
        step(1, 0, 1);
        idle(3, 1);
        idle(6, 0);

        // asynchronous reset from RUN
        step(0, 1, 0);
        idle(5, 0);
        check_async_reset();
        idle(3, 0);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        end
        idle(40, 0);
        step(0, 1, 0);
        idle(40, 0);

        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/airlock_timer.md
Name: airlock_timer

Overview:
- Elapsed-time counter that feeds the airlock interlock FSMs (arriving and leaving).
- Consumes their rstCounter pulses and produces the counterVal they compare against, in units of TICK_CYCLES clocks (one unit = 5 s on the board).
- Also drives a 7-segment digit showing the current count, plus tick and saturation status.

Parameters:
- TICK_CYCLES, 250000000, clocks per count unit (5 s at 50 MHz); legal range 2..2^PS_WIDTH.
- PS_WIDTH, 28, prescaler width.
- COUNT_WIDTH, 3, width of counterVal.

Ports:
- clock  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rstCounterA  input  1  restart request from the arriving FSM.
- rstCounterB  input  1  restart request from the leaving FSM.
- hold  input  1  freeze timing while high, e.g. port sensor fault.
- counterVal  output  COUNT_WIDTH  elapsed units since last restart.
- tick  output  1  one-cycle pulse on the cycle counterVal increments.
- saturated  output  1  high while counterVal is at its maximum.
- running  output  1  high in RUN state.
- display  output  7  active-low 7-seg digit of counterVal; blank (7'b1111111) in IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, prescaler=0, counterVal=0, tick=0, saturated=0, running=0, display=blank.
- restart = rstCounterA | rstCounterB.
  - Simultaneous requests act as a single restart.
  - Sampled at the rising edge; the inputs are combinational outputs of the FSMs.
- States:
  - IDLE: no counting. On restart, go to RUN with prescaler=0 and counterVal=0.
  - RUN:
    - Each edge with no restart and no hold: prescaler+1.
    - When prescaler==TICK_CYCLES-1: prescaler<=0, counterVal<=counterVal+1, tick<=1 for exactly that following cycle.
    - If the increment makes counterVal == 2^COUNT_WIDTH-1, go to SAT.
  - SAT: counterVal held at max (3'b111), saturated=1, prescaler frozen at 0, no further ticks. Restart returns to RUN with counterVal=0.
- Priority: restart > hold > prescaler advance. Restart while hold is high still clears and enters RUN; hold then freezes at 0.
- hold in RUN freezes prescaler and counterVal. Timing resumes from the frozen prescaler value when hold drops; no ticks are lost or duplicated.
- Latency: after the restart edge, counterVal=0. It becomes 1 after exactly TICK_CYCLES further unheld edges, and n after n*TICK_CYCLES.
- Restart in RUN mid-interval discards the partial prescaler count.
- counterVal, tick, saturated and running are registered outputs.
- display is combinational from state and counterVal, active-low segments g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
- running = (state==RUN). saturated = (state==SAT).
- Undefined state encoding recovers to IDLE on the next edge.

Decomposition:
- Shared package airlock_pkg:
  - State encoding for IDLE/RUN/SAT.
  - 7-seg constants: digits 0-7, blank, and the l/e/p letters already used by the interlock FSMs.
- One sub-module: seg7_digit, a combinational COUNT_WIDTH-to-7 active-low decoder with a blank input. It is reusable by the interlock display mux.

Test Plan:
Bench uses TICK_CYCLES=4.
- Reset: assert rst mid-cycle -> outputs clear without waiting for a clock edge; state IDLE; display=1111111; 20 idle cycles give counterVal=0, tick never 1.
- Basic count: pulse rstCounterB for 1 cycle -> counterVal=0 and running=1 next cycle. counterVal=1 after 4 more edges, 2 after 8, 4 after 16. tick pulses once per step; display=0011001 at count 4.
- Saturation: run 28 edges after restart -> counterVal=7, saturated=1, running=0. 10 more edges -> still 7, no tick. Pulse rstCounterA -> counterVal=0, running=1.
- Hold: restart, advance 2 edges, hold=1 for 10 edges -> counterVal stays 0. Release -> counterVal=1 after exactly 2 more edges.
- Simultaneous/mid-interval restart: at counterVal=3 with prescaler=2, pulse rstCounterA and rstCounterB together for 1 cycle -> single restart, counterVal=0, next increment exactly 4 edges later.
- Restart during hold: hold=1 and restart together -> counterVal=0 with prescaler frozen. Drop hold -> count 1 after 4 edges.
